// File: rtl/counter_binary_down_if.sv
// rtl/counter_binary_down_if.sv - control/status bundle for the prescaled down counter
interface counter_binary_down_if #(
  parameter int NBITS = 4
);
  logic             enable;
  logic             load;
  logic [NBITS-1:0] load_value;
  logic [NBITS-1:0] counter;
  logic             borrow;
  logic             zero;
  logic             done;

  modport master (
    output enable, load, load_value,
    input  counter, borrow, zero, done
  );

  modport slave (
    input  enable, load, load_value,
    output counter, borrow, zero, done
  );
endinterface

// File: rtl/counter_binary_down.sv
// rtl/counter_binary_down.sv - prescaled binary down counter with reload or one-shot hold
module counter_binary_down #(
  parameter int               NBITS         = 4,
  parameter logic [NBITS-1:0] MAXIMUM_VALUE = 4'h9,
  parameter int               FRECUENCY     = 10000000,
  parameter bit               AUTO_RELOAD   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_binary_down_if.slave bus
);
  localparam int PW = (FRECUENCY > 1) ? $clog2(FRECUENCY) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(FRECUENCY - 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [NBITS-1:0] counter_q, counter_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             tick;
  logic [NBITS-1:0] load_sat;

  // Prescaler acts only as a clock enable; no derived clock leaves this block.
  assign tick     = bus.enable && (state_q == RUN) && (presc_q == PRESC_LAST);
  assign load_sat = (bus.load_value > MAXIMUM_VALUE) ? MAXIMUM_VALUE : bus.load_value;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    counter_d = counter_q;
    borrow_d  = 1'b0;
    done_d    = done_q;
    if (bus.load) begin
      counter_d = load_sat;
      presc_d   = '0;
      state_d   = RUN;
      done_d    = 1'b0;
    end else if (state_q == RUN && bus.enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (counter_q != '0) begin
          counter_d = counter_q - NBITS'(1);
        end else if (AUTO_RELOAD) begin
          counter_d = MAXIMUM_VALUE;
          borrow_d  = 1'b1;
        end else begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      presc_q   <= '0;
      counter_q <= MAXIMUM_VALUE;
      borrow_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      counter_q <= counter_d;
      borrow_q  <= borrow_d;
      done_q    <= done_d;
    end
  end

  assign bus.counter = counter_q;
  assign bus.borrow  = borrow_q;
  assign bus.done    = done_q;
  assign bus.zero    = (counter_q == '0);
endmodule

// File: tb/tb_counter_binary_down.sv
// tb/tb_counter_binary_down.sv - directed self-checking bench for counter_binary_down
module tb_counter_binary_down;
  logic clk;
  logic rst_a, rst_b, rst_c;
  int   total;
  int   bad;

  counter_binary_down_if #(.NBITS(4)) ifa ();
  counter_binary_down_if #(.NBITS(4)) ifb ();
  counter_binary_down_if #(.NBITS(4)) ifc ();

  counter_binary_down #(.NBITS(4), .MAXIMUM_VALUE(4'h9), .FRECUENCY(2), .AUTO_RELOAD(1'b1))
    u_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  counter_binary_down #(.NBITS(4), .MAXIMUM_VALUE(4'h9), .FRECUENCY(2), .AUTO_RELOAD(1'b0))
    u_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));
  counter_binary_down #(.NBITS(4), .MAXIMUM_VALUE(4'h9), .FRECUENCY(1), .AUTO_RELOAD(1'b1))
    u_c (.clk(clk), .reset(rst_c), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int ob_cnt [2:10];
    int ob_done[2:10];
    ob_cnt  = '{2, 1, 1, 0, 0, 0, 0, 0, 0};
    ob_done = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    total = 0;
    bad   = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.enable = 1'b0; ifa.load = 1'b0; ifa.load_value = '0;
    ifb.enable = 1'b0; ifb.load = 1'b0; ifb.load_value = '0;
    ifc.enable = 1'b0; ifc.load = 1'b0; ifc.load_value = '0;
    step();
    step();

    check("rst_counter", int'(ifa.counter), 9);
    check("rst_borrow", int'(ifa.borrow), 0);
    check("rst_zero", int'(ifa.zero), 0);
    check("rst_done", int'(ifb.done), 0);

    // free run: one step per two clocks, wrap with a single borrow
    rst_a = 1'b0;
    ifa.enable = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k < 20) exp_cnt = 9 - k / 2;
      else if (k < 22) exp_cnt = 9;
      else exp_cnt = 8;
      check($sformatf("free_cnt_%0d", k), int'(ifa.counter), exp_cnt);
      check($sformatf("free_borrow_%0d", k), int'(ifa.borrow), (k == 20) ? 1 : 0);
      check($sformatf("free_zero_%0d", k), int'(ifa.zero), (exp_cnt == 0) ? 1 : 0);
    end

    // enable toggling halves the rate
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      ifa.enable = k[0];
      step();
      check($sformatf("gate_cnt_%0d", k), int'(ifa.counter), 9 - (k + 1) / 4);
    end

    // load on the tick edge wins, prescaler restarts
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    ifa.enable = 1'b1;
    step();
    check("coll_pre", int'(ifa.counter), 9);
    ifa.load = 1'b1; ifa.load_value = 4'd4;
    step();
    check("coll_load", int'(ifa.counter), 4);
    ifa.load = 1'b0;
    step();
    check("coll_hold", int'(ifa.counter), 4);
    step();
    check("coll_dec", int'(ifa.counter), 3);
    ifa.load = 1'b1; ifa.load_value = 4'd15;
    step();
    check("coll_sat", int'(ifa.counter), 9);
    check("coll_borrow", int'(ifa.borrow), 0);
    ifa.load = 1'b0;

    // async reset mid-count takes effect without a clock edge
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (12) step();
    check("areset_pre", int'(ifa.counter), 3);
    #2 rst_a = 1'b1;
    #1;
    check("areset_cnt", int'(ifa.counter), 9);
    check("areset_borrow", int'(ifa.borrow), 0);
    @(negedge clk);
    rst_a = 1'b0;
    step();
    check("areset_post1", int'(ifa.counter), 9);
    check("areset_post1_borrow", int'(ifa.borrow), 0);
    step();
    check("areset_post2", int'(ifa.counter), 8);

    // one-shot: count down, hold at zero, reload resumes
    rst_b = 1'b0;
    ifb.enable = 1'b1;
    ifb.load = 1'b1; ifb.load_value = 4'd2;
    step();
    check("os_load", int'(ifb.counter), 2);
    check("os_load_done", int'(ifb.done), 0);
    ifb.load = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      check($sformatf("os_cnt_%0d", k), int'(ifb.counter), ob_cnt[k]);
      check($sformatf("os_done_%0d", k), int'(ifb.done), ob_done[k]);
      check($sformatf("os_borrow_%0d", k), int'(ifb.borrow), 0);
    end
    ifb.load = 1'b1; ifb.load_value = 4'd5;
    step();
    check("os_reload", int'(ifb.counter), 5);
    check("os_reload_done", int'(ifb.done), 0);
    ifb.load = 1'b0;
    step();
    check("os_resume1", int'(ifb.counter), 5);
    step();
    check("os_resume2", int'(ifb.counter), 4);

    // async reset while in HOLD clears done immediately
    ifb.load = 1'b1; ifb.load_value = 4'd0;
    step();
    ifb.load = 1'b0;
    step();
    check("os_h_pre", int'(ifb.done), 0);
    step();
    check("os_h_done", int'(ifb.done), 1);
    #2 rst_b = 1'b1;
    #1;
    check("os_h_rst_done", int'(ifb.done), 0);
    check("os_h_rst_cnt", int'(ifb.counter), 9);
    @(negedge clk);
    rst_b = 1'b0;
    step();
    check("os_h_post_done", int'(ifb.done), 0);
    check("os_h_post_cnt", int'(ifb.counter), 9);

    // FRECUENCY = 1: decrement every enabled cycle
    rst_c = 1'b0;
    ifc.enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k <= 9) exp_cnt = 9 - k;
      else if (k == 10) exp_cnt = 9;
      else exp_cnt = 8;
      check($sformatf("f1_cnt_%0d", k), int'(ifc.counter), exp_cnt);
      check($sformatf("f1_borrow_%0d", k), int'(ifc.borrow), (k == 10) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_binary_down.md
COUNTER_BINARY_DOWN -- requirements
Module: counter_binary_down

Interface
REQ-001 Parameter MAXIMUM_VALUE, default 4'h9: wrap/reload value of the count.
REQ-002 Parameter NBITS, default 4: count width.
REQ-003 Parameter FRECUENCY, default 10000000: clk cycles per count tick, legal range >= 1.
REQ-004 Parameter AUTO_RELOAD, default 1: 1 = wrap 0 -> MAXIMUM_VALUE; 0 = stop at 0.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  count enable; high lets the prescaler and counter advance.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_value  input  NBITS  value captured on load.
REQ-010 counter  output  NBITS  current count, registered.
REQ-011 borrow  output  1  one-clk pulse on the 0 -> MAXIMUM_VALUE wrap, registered.
REQ-012 zero  output  1  high while counter == 0, combinational from counter.
REQ-013 done  output  1  high in HOLD state (AUTO_RELOAD = 0 only), registered.

Function
REQ-014 The block SHALL use the internal prescaler as a clock enable; it SHALL NOT generate a derived or gated clock.
REQ-015 Prescaler SHALL count 0..FRECUENCY-1 while enable = 1 and state = RUN, wrap to 0, and hold when enable = 0.
REQ-016 Tick SHALL be an internal one-cycle strobe, true when prescaler == FRECUENCY-1 and enable = 1 and state = RUN.
REQ-017 With FRECUENCY = 1, tick SHALL occur on every enabled RUN cycle.
REQ-018 FSM states SHALL be RUN and HOLD.
- RUN -> HOLD: tick with counter == 0 and AUTO_RELOAD = 0.
- HOLD -> RUN: load only.
REQ-019 On tick with counter != 0, counter SHALL decrement by 1 at the same edge.
REQ-020 On tick with counter == 0 and AUTO_RELOAD = 1:
- counter SHALL become MAXIMUM_VALUE.
- borrow SHALL be 1 for exactly the following cycle, coincident with counter == MAXIMUM_VALUE.
REQ-021 On tick with counter == 0 and AUTO_RELOAD = 0:
- counter SHALL stay 0.
- done SHALL go 1 at the next edge.
- borrow SHALL stay 0.
REQ-022 In HOLD, counter and prescaler SHALL be frozen regardless of enable.
REQ-023 load = 1 SHALL take priority over tick at the same edge and be independent of enable:
- counter <= min(load_value, MAXIMUM_VALUE).
- prescaler <= 0.
- state <= RUN, done <= 0, borrow <= 0.
REQ-024 A load_value above MAXIMUM_VALUE SHALL saturate to MAXIMUM_VALUE.
REQ-025 The counter SHALL never hold a value above MAXIMUM_VALUE; all arithmetic SHALL be NBITS wide with no carry-out.
REQ-026 borrow SHALL never be high for two consecutive cycles, and SHALL never be high when FRECUENCY > 1 unless the preceding edge was a wrap tick.

Reset
REQ-027 While reset = 1, regardless of clk:
- counter SHALL be MAXIMUM_VALUE.
- prescaler SHALL be 0.
- borrow SHALL be 0, done SHALL be 0.
- state SHALL be RUN.
REQ-028 Reset asserted mid-count or in HOLD SHALL abort the operation immediately, with no pending borrow/done after release.
REQ-029 After reset deasserts, the first tick SHALL occur FRECUENCY enabled cycles later.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, using FRECUENCY = 2, MAXIMUM_VALUE = 9, NBITS = 4 unless stated otherwise.
- Free run: enable = 1 for 22 cycles after reset -> counter 9,9,8,8,...,0,0,9 (one step per 2 clk); borrow high only in the cycle counter first shows 9 after 0; zero high while counter = 0.
- Enable gating: toggle enable 1/0 every cycle -> counter steps once per 4 clk; prescaler frozen while enable = 0.
- Load/tick collision: load = 1, load_value = 4 on a tick edge -> counter = 4 (not 3); next decrement 2 enabled cycles later; load_value = 15 -> counter = 9.
- One-shot (AUTO_RELOAD = 0): load 2, enable = 1 -> counter 2,1,0 then done = 1 and counter held at 0 with enable high; borrow never asserted; load 5 -> done = 0, counting resumes from 5.
- Async reset: assert reset between clk edges at counter = 3 -> counter = 9, borrow = 0, done = 0 immediately, without a clk edge.
- FRECUENCY = 1: enable = 1 -> counter decrements every cycle 9..0,9 with a single-cycle borrow per wrap.
